led_matrix_scan: RTL and testbench

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

---
 rtl/led_matrix_scan.sv | 140 ++++++++++++++
 tb/tb_led_matrix_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// Row-multiplexed LED matrix scanner with double-buffered frame memory,
// frame-synchronous bank swap and horizontal scrolling.
// Optional PWM brightness gating is enabled by defining LED_MATRIX_PWM_EN.
module led_matrix_scan #(
  parameter int unsigned ROWS       = 16,
  parameter int unsigned COLS       = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned SCROLL_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [3:0]       wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  input  logic             scroll_en,
  input  logic             scroll_dir,
`ifdef LED_MATRIX_PWM_EN
  input  logic [3:0]       brightness,
`endif
  output logic [3:0]       row_bin,
  output logic [COLS-1:0]  col
);

  localparam int unsigned ROW_W = 4;
  localparam int unsigned OFF_W = $clog2(COLS);
  localparam int unsigned FC_W  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             bank_q, bank_d;
  logic             pend_q, pend_d;
  logic             ack_q, ack_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [COLS-1:0]  bank0_q [ROWS];
  logic [COLS-1:0]  bank0_d [ROWS];
  logic [COLS-1:0]  bank1_q [ROWS];
  logic [COLS-1:0]  bank1_d [ROWS];

  logic             tick;
  logic             frame_end;
  logic             do_swap;
  logic [COLS-1:0]  front_row;
  logic [COLS-1:0]  col_rot;

  // Next-state: prescaler, row scan, swap handshake, back-bank writes, scroll
  always_comb begin
    tick      = &cnt_q;
    frame_end = tick && (row_q == ROW_W'(ROWS - 1));
    do_swap   = frame_end && (pend_q || swap_req);

    cnt_d  = cnt_q + DIV_W'(1);
    row_d  = row_q;
    bank_d = bank_q ^ do_swap;
    pend_d = do_swap ? 1'b0 : (pend_q | swap_req);
    ack_d  = do_swap;
    off_d  = off_q;
    fcnt_d = fcnt_q;
    for (int r = 0; r < int'(ROWS); r++) begin
      bank0_d[r] = bank0_q[r];
      bank1_d[r] = bank1_q[r];
    end

    if (tick) begin
      row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    end

    // Writes target the current back bank; out-of-range rows never match
    for (int r = 0; r < int'(ROWS); r++) begin
      if (wr_en && (wr_row == ROW_W'(r))) begin
        if (bank_q) bank0_d[r] = wr_data;
        else        bank1_d[r] = wr_data;
      end
    end

    if (!scroll_en) begin
      fcnt_d = '0;
    end else if (frame_end) begin
      if (fcnt_q == FC_W'(SCROLL_DIV - 1)) begin
        fcnt_d = '0;
        if (!scroll_dir) off_d = (off_q == OFF_W'(COLS - 1)) ? '0 : off_q + OFF_W'(1);
        else             off_d = (off_q == '0) ? OFF_W'(COLS - 1) : off_q - OFF_W'(1);
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      row_q  <= '0;
      bank_q <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
      off_q  <= '0;
      fcnt_q <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        bank0_q[r] <= '0;
        bank1_q[r] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      row_q  <= row_d;
      bank_q <= bank_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      off_q  <= off_d;
      fcnt_q <= fcnt_d;
      for (int r = 0; r < int'(ROWS); r++) begin
        bank0_q[r] <= bank0_d[r];
        bank1_q[r] <= bank1_d[r];
      end
    end
  end

  // Column drive: front-bank row rotated left by the scroll offset, no added latency
  always_comb begin
    front_row = '0;
    col_rot   = '0;
    for (int r = 0; r < int'(ROWS); r++) begin
      if (row_q == ROW_W'(r)) front_row = bank_q ? bank1_q[r] : bank0_q[r];
    end
    for (int unsigned c = 0; c < COLS; c++) begin
      col_rot[OFF_W'((c + 32'(off_q)) % COLS)] = front_row[c];
    end
`ifdef LED_MATRIX_PWM_EN
    col = (cnt_q[DIV_W-1 -: 4] > brightness) ? '0 : col_rot;
`else
    col = col_rot;
`endif
  end

  assign row_bin  = row_q;
  assign swap_ack = ack_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed self-checking bench for led_matrix_scan (ROWS=4, COLS=8, DIV_W=4, SCROLL_DIV=2).
module tb_led_matrix_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;
  logic       scroll_en;
  logic       scroll_dir;
  logic [3:0] row_bin;
  logic [7:0] col;
`ifdef LED_MATRIX_PWM_EN
  logic [3:0] brightness;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  always #5 clk = ~clk;

  led_matrix_scan #(.ROWS(4), .COLS(8), .DIV_W(4), .SCROLL_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .swap_req  (swap_req),
    .swap_ack  (swap_ack),
    .scroll_en (scroll_en),
    .scroll_dir(scroll_dir),
`ifdef LED_MATRIX_PWM_EN
    .brightness(brightness),
`endif
    .row_bin   (row_bin),
    .col       (col)
  );

  typedef struct {
    logic       we;
    logic [3:0] wrow;
    logic [7:0] wdata;
    logic       swp;
    int         wait_n;
    logic [3:0] e_row;
    logic [7:0] e_col;
    logic       e_ack;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got 0x%0h expected 0x%0h", nm, t, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    int acks;
    int ack_t;
    int bad;
    logic [7:0] exp_col;

    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
    scroll_en = 1'b0; scroll_dir = 1'b0;
`ifdef LED_MATRIX_PWM_EN
    brightness = 4'd15;
`endif

    //            we    row   data   swp  wait row  col    ack
    vt[0]  = '{1'b0, 4'd0, 8'h00, 1'b0, 16, 4'd1, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 4'd0, 8'h00, 1'b0, 16, 4'd2, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 4'd0, 8'h01, 1'b0,  1, 4'd2, 8'h00, 1'b0};
    vt[3]  = '{1'b1, 4'd1, 8'h02, 1'b0,  1, 4'd2, 8'h00, 1'b0};
    vt[4]  = '{1'b1, 4'd2, 8'h04, 1'b0,  1, 4'd2, 8'h00, 1'b0};
    vt[5]  = '{1'b1, 4'd3, 8'h08, 1'b0,  1, 4'd2, 8'h00, 1'b0};
    vt[6]  = '{1'b1, 4'd5, 8'hFF, 1'b0,  1, 4'd2, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 4'd0, 8'h00, 1'b1,  1, 4'd2, 8'h00, 1'b0};
    vt[8]  = '{1'b0, 4'd0, 8'h00, 1'b0, 25, 4'd3, 8'h00, 1'b0};
    vt[9]  = '{1'b0, 4'd0, 8'h00, 1'b0,  1, 4'd0, 8'h01, 1'b1};
    vt[10] = '{1'b0, 4'd0, 8'h00, 1'b0,  1, 4'd0, 8'h01, 1'b0};
    vt[11] = '{1'b0, 4'd0, 8'h00, 1'b0, 15, 4'd1, 8'h02, 1'b0};
    vt[12] = '{1'b0, 4'd0, 8'h00, 1'b0, 16, 4'd2, 8'h04, 1'b0};
    vt[13] = '{1'b0, 4'd0, 8'h00, 1'b0, 16, 4'd3, 8'h08, 1'b0};
    vt[14] = '{1'b0, 4'd0, 8'h00, 1'b0, 16, 4'd0, 8'h01, 1'b0};

    // Reset state
    step(3);
    chk("rst_row", 32'(row_bin), 0);
    chk("rst_col", 32'(col), 0);
    chk("rst_ack", 32'(swap_ack), 0);
    rst = 1'b0;
    t = 0;

    // Scan, buffered writes and one swap
    for (int i = 0; i < 15; i++) begin
      wr_en = vt[i].we; wr_row = vt[i].wrow; wr_data = vt[i].wdata; swap_req = vt[i].swp;
      step(1);
      wr_en = 1'b0; swap_req = 1'b0;
      if (vt[i].wait_n > 1) step(vt[i].wait_n - 1);
      chk($sformatf("vec%0d_row", i), 32'(row_bin), 32'(vt[i].e_row));
      chk($sformatf("vec%0d_col", i), 32'(col), 32'(vt[i].e_col));
      chk($sformatf("vec%0d_ack", i), 32'(swap_ack), 32'(vt[i].e_ack));
    end

    // Double swap_req in one frame; write on the swap edge lands in the new front
    wr_en = 1'b1; wr_row = 4'd0; wr_data = 8'h01; swap_req = 1'b1;
    step(1);
    wr_en = 1'b0; swap_req = 1'b0;
    step(5);
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
    acks = 0; ack_t = -1;
    while (t < 210) begin
      if (t == 191) begin wr_en = 1'b1; wr_row = 4'd1; wr_data = 8'h40; end
      step(1);
      wr_en = 1'b0;
      if (swap_ack) begin acks++; ack_t = t; end
    end
    chk("dbl_swap_count", acks, 1);
    chk("dbl_swap_time", ack_t, 192);
    chk("swap_wr_row", 32'(row_bin), 1);
    chk("swap_wr_col", 32'(col), 32'h40);

    // Scrolling left, then right, then hold
    scroll_en = 1'b1; scroll_dir = 1'b0;
    step(46);
    for (int f = 1; f <= 16; f++) begin
      if (f > 1) step(64);
      exp_col = 8'h01 << ((f / 2) % 8);
      chk($sformatf("scroll_l_f%0d_row", f), 32'(row_bin), 0);
      chk($sformatf("scroll_l_f%0d", f), 32'(col), 32'(exp_col));
    end
    scroll_dir = 1'b1;
    step(64);
    chk("scroll_r_f1", 32'(col), 32'h01);
    step(64);
    chk("scroll_r_f2", 32'(col), 32'h80);
    scroll_en = 1'b0;
    step(192);
    chk("scroll_hold", 32'(col), 32'h80);

    // Reset with a pending swap and a write in flight
    step(20);
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
    wr_en = 1'b1; wr_row = 4'd2; wr_data = 8'hFF;
    step(1);
    wr_en = 1'b0;
    step(4);
    rst = 1'b1;
    #1;
    chk("midrst_row", 32'(row_bin), 0);
    chk("midrst_col", 32'(col), 0);
    chk("midrst_ack", 32'(swap_ack), 0);
    step(2);
    rst = 1'b0;
    t = 0;
    step(15);
    chk("post_rst_row_t15", 32'(row_bin), 0);
    step(1);
    chk("post_rst_row_t16", 32'(row_bin), 1);
    bad = 0;
    repeat (150) begin
      step(1);
      if (swap_ack !== 1'b0 || col !== 8'h00) bad++;
    end
    chk("post_rst_quiet", bad, 0);

`ifdef LED_MATRIX_PWM_EN
    // PWM gating at brightness 3: on for cnt 0..3 of each slot
    for (int r = 0; r < 4; r++) begin
      wr_en = 1'b1; wr_row = 4'(r); wr_data = 8'hFF;
      step(1);
    end
    wr_en = 1'b0;
    swap_req = 1'b1;
    step(1);
    swap_req = 1'b0;
    brightness = 4'd3;
    step(192 - t);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("pwm_cnt%0d", i), 32'(col), (i < 4) ? 32'hFF : 0);
      step(1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
